bus_arbiter: RTL and testbench



---
 rtl/bus_pkg.sv | 16 +
 rtl/rr_picker.sv | 35 +++
 rtl/bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_bus_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the system bus arbiter and its helpers.
// Holds the arbiter state encoding and the bus field widths.
package bus_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int MASK_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      DROP  = 2'd2,
      HOLD  = 2'd3
   } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first active requester after the last winner.
// Purely combinational so other schedulers can reuse it.
module rr_picker #(
   parameter int MASTERS = 2,
   parameter int IW      = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
   input  logic [MASTERS-1:0] active,
   input  logic [IW-1:0]      last,
   output logic [MASTERS-1:0] pick,
   output logic [IW-1:0]      pick_idx
);

   int            idx;
   logic [IW-1:0] sel;
   logic          found;

   always_comb begin
      pick     = '0;
      pick_idx = '0;
      found    = 1'b0;
      idx      = 0;
      sel      = '0;
      for (int k = 1; k <= MASTERS; k++) begin
         idx = int'(last) + k;
         if (idx >= MASTERS) idx = idx - MASTERS;
         sel = IW'(idx);
         if (!found && active[sel]) begin
            found     = 1'b1;
            pick[sel] = 1'b1;
            pick_idx  = sel;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared system bus with a completion watchdog.
// Ownership spans the whole fc handshake plus one turnaround cycle.
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int MASTERS = 2,
   parameter int TIMEOUT = 255
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [ADDR_W*MASTERS-1:0]   m_addr,
   input  logic [DATA_W*MASTERS-1:0]   m_wdata,
   input  logic [MASK_W*MASTERS-1:0]   m_mask,
   input  logic [MASTERS-1:0]          m_rd,
   input  logic [MASTERS-1:0]          m_wr,
   output logic [DATA_W-1:0]           m_rdata,
   output logic [MASTERS-1:0]          m_fc,
   output logic [MASTERS-1:0]          m_err,
   output logic [MASTERS-1:0]          grant,
   output logic [ADDR_W-1:0]           addr_bus,
   inout  wire  [DATA_W-1:0]           data_bus,
   output logic                        rd_bus,
   output logic                        wr_bus,
   output logic [MASK_W-1:0]           data_mask_bus,
   input  logic                        fc_bus
);

   localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
   localparam int TW = $clog2(TIMEOUT);

   arb_state_e         state_q, state_d;
   logic [IW-1:0]      last_q, last_d;
   logic [MASTERS-1:0] grant_q, grant_d;
   logic [TW-1:0]      timer_q, timer_d;
   logic               tmo_q, tmo_d;

   logic [MASTERS-1:0] active, pick;
   logic [IW-1:0]      pick_idx;
   logic               own_rd, own_wr, own_act;
   logic               fc_ok, busy, expire, kill, drv;
   logic [ADDR_W-1:0]  own_addr;
   logic [DATA_W-1:0]  own_wdata;
   logic [MASK_W-1:0]  own_mask;

   assign active = m_rd | m_wr;

   rr_picker #(
      .MASTERS (MASTERS),
      .IW      (IW)
   ) u_pick (
      .active   (active),
      .last     (last_q),
      .pick     (pick),
      .pick_idx (pick_idx)
   );

   always_comb begin
      own_rd    = m_rd[last_q];
      own_wr    = m_wr[last_q];
      own_act   = own_rd | own_wr;
      own_addr  = m_addr[ADDR_W*last_q +: ADDR_W];
      own_wdata = m_wdata[DATA_W*last_q +: DATA_W];
      own_mask  = m_mask[MASK_W*last_q +: MASK_W];
      // z or x on the pulled-down fc line must read as not done
      fc_ok = 1'b0;
      if (fc_bus == 1'b1) fc_ok = 1'b1;
      busy   = (state_q == GRANT) || (state_q == DROP);
      expire = (state_q == GRANT) && own_act && !fc_ok &&
               (timer_q == TW'(TIMEOUT - 1));
      kill   = expire || ((state_q == DROP) && tmo_q);
      drv    = busy && !kill && own_wr;
   end

   always_comb begin
      addr_bus      = busy ? own_addr : '0;
      data_mask_bus = busy ? own_mask : '0;
      rd_bus        = busy && !kill && own_rd;
      wr_bus        = busy && !kill && own_wr;
      m_fc          = '0;
      m_err         = '0;
      if (busy) begin
         m_fc[last_q]  = kill | fc_ok;
         m_err[last_q] = expire;
      end
   end

   assign data_bus = drv ? own_wdata : {DATA_W{1'bz}};
   assign m_rdata  = data_bus;
   assign grant    = grant_q;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      grant_d = grant_q;
      timer_d = timer_q;
      tmo_d   = tmo_q;
      unique case (state_q)
         IDLE: begin
            if (|active) begin
               state_d = GRANT;
               last_d  = pick_idx;
               grant_d = pick;
            end
         end
         GRANT: begin
            timer_d = timer_q + 1'b1;
            if (!own_act) begin
               state_d = HOLD;
               grant_d = '0;
            end else if (fc_ok) begin
               state_d = DROP;
            end else if (expire) begin
               state_d = DROP;
               tmo_d   = 1'b1;
            end
         end
         DROP: begin
            if (!own_act) begin
               state_d = HOLD;
               grant_d = '0;
            end
         end
         HOLD: begin
            state_d = IDLE;
            timer_d = '0;
            tmo_d   = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= IW'(MASTERS - 1);
         grant_q <= '0;
         timer_q <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         timer_q <= timer_d;
         tmo_q   <= tmo_d;
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: randomized masters, latency-keyed slave,
// and a round-robin reference applied on every new grant.
module tb_bus_arbiter;

   localparam int M  = 2;
   localparam int TO = 8;
   localparam int K_RD = 0, K_WR = 1, K_ERR = 2, K_ABORT = 3;

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [63:0]   m_addr, m_wdata;
   logic [7:0]    m_mask;
   logic [1:0]    m_rd, m_wr;
   logic [31:0]   m_rdata;
   logic [1:0]    m_fc, m_err, grant;
   logic [31:0]   addr_bus;
   wire  [31:0]   data_bus;
   logic          rd_bus, wr_bus;
   logic [3:0]    data_mask_bus;
   logic          fc_bus;

   int checks = 0;
   int errors = 0;

   exp_t sbq[2][$];
   int   gorder[$];

   bus_arbiter #(.MASTERS(M), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_mask(m_mask),
      .m_rd(m_rd), .m_wr(m_wr),
      .m_rdata(m_rdata), .m_fc(m_fc), .m_err(m_err), .grant(grant),
      .addr_bus(addr_bus), .data_bus(data_bus),
      .rd_bus(rd_bus), .wr_bus(wr_bus),
      .data_mask_bus(data_mask_bus), .fc_bus(fc_bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rfun(input logic [31:0] a);
      return a ^ 32'hA5C3_5A3C;
   endfunction

   function automatic int rr_pick(input logic [1:0] req, input int last);
      for (int k = 1; k <= M; k++)
         if (req[(last + k) % M]) return (last + k) % M;
      return -1;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   // Slave: addr[31] set means unmapped; otherwise fc after addr[3:2]+1 cycles.
   int scnt;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         scnt   <= 0;
         fc_bus <= 1'b0;
      end else if (rd_bus | wr_bus) begin
         fc_bus <= !addr_bus[31] && (scnt >= int'(addr_bus[3:2]));
         scnt   <= scnt + 1;
      end else begin
         scnt   <= 0;
         fc_bus <= 1'b0;
      end
   end

   assign data_bus = (rd_bus & ~wr_bus) ? rfun(addr_bus) : 32'bz;

   // Monitor
   int          last_m, gcnt, eo;
   logic [1:0]  fc_prev, g_prev, g_prev2, req_prev, req;
   exp_t        e;

   always @(negedge clk) begin
      if (rst) begin
         last_m   = M - 1;
         gcnt     = 0;
         fc_prev  = '0;
         g_prev   = '0;
         g_prev2  = '0;
         req_prev = '0;
         gorder.delete();
      end else begin
         req = m_rd | m_wr;
         if (grant != 0 && g_prev == 0) begin
            eo = rr_pick(req_prev, last_m);
            chk("rr_grant", grant, (eo < 0) ? 64'hBAD : (64'd1 << eo));
            chk("hold_gap", g_prev2, 0);
            last_m = eo;
            gorder.push_back(eo);
            gcnt = 0;
         end else begin
            gcnt++;
         end
         if (g_prev == 0 && g_prev2 == 0 && req_prev != 0)
            chk("arb_latency", grant != 0, 1);
         if (grant == 0)
            chk("idle_bus", {addr_bus, data_mask_bus, rd_bus, wr_bus, m_fc}, 0);
         for (int i = 0; i < M; i++) begin
            if (m_err[i] || (m_fc[i] && !fc_prev[i])) begin
               if (sbq[i].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL sb_unexpected m%0d: got fc=%0b err=%0b, required none",
                           i, m_fc[i], m_err[i]);
               end else begin
                  e = sbq[i].pop_front();
                  chk("resp_kind", m_err[i] ? K_ERR : (m_wr[i] ? K_WR : K_RD), e.kind);
                  chk("resp_owner", grant, 64'd1 << i);
                  if (m_err[i]) begin
                     chk("err_cycle", gcnt, TO - 1);
                     chk("err_fc", m_fc[i], 1);
                     chk("err_rdwr", {rd_bus, wr_bus}, 0);
                  end else begin
                     chk("bus_addr", addr_bus, e.addr);
                     if (e.kind == K_RD) chk("rdata", m_rdata, rfun(e.addr));
                     if (e.kind == K_WR) begin
                        chk("wdata", data_bus, e.data);
                        chk("wmask", data_mask_bus, e.mask);
                     end
                  end
               end
            end
         end
         fc_prev  = m_fc;
         g_prev2  = g_prev;
         g_prev   = grant;
         req_prev = req;
      end
   end

   task automatic master_txn(input int i, input int kind,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] mk, input int abort_after);
      exp_t x;
      int   n;
      bit   done;
      x.kind = kind; x.addr = a; x.data = d; x.mask = mk;
      if (kind != K_ABORT) sbq[i].push_back(x);
      @(posedge clk); #1;
      m_addr[32*i +: 32]  = a;
      m_wdata[32*i +: 32] = d;
      m_mask[4*i +: 4]    = mk;
      m_rd[i] = (kind != K_WR);
      m_wr[i] = (kind == K_WR);
      n = 0;
      done = 0;
      while (!done) begin
         @(negedge clk);
         n++;
         if (kind == K_ABORT) done = (n >= abort_after);
         else if (m_fc[i]) done = 1;
         else if (n >= 60) begin
            checks++;
            errors++;
            $display("FAIL txn_timeout m%0d: got no fc in %0d cycles, required fc", i, n);
            done = 1;
         end
      end
      @(posedge clk); #1;
      m_rd[i] = 1'b0;
      m_wr[i] = 1'b0;
   endtask

   task automatic master_run(input int i, input int n);
      for (int t = 0; t < n; t++) begin
         int          u, lat, kind, ab;
         logic [31:0] a;
         u    = $urandom_range(0, 9);
         lat  = $urandom_range(0, 3);
         a    = {1'b0, 27'($urandom), 2'(lat), 2'b00};
         kind = K_RD;
         ab   = 0;
         if (u == 0) begin
            kind  = K_ERR;
            a[31] = 1'b1;
         end else if (u == 1) begin
            kind   = K_ABORT;
            a[3:2] = 2'd3;
            ab     = $urandom_range(1, 3);
         end else if (u < 6) begin
            kind = K_WR;
         end
         master_txn(i, kind, a, $urandom, 4'($urandom), ab);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      exp_t x;
      rst = 1'b1;
      m_addr = '0; m_wdata = '0; m_mask = '0; m_rd = '0; m_wr = '0;
      repeat (3) @(posedge clk); #1;
      chk("rst_grant", grant, 0);
      chk("rst_fc_err", {m_fc, m_err}, 0);
      chk("rst_bus", {addr_bus, data_mask_bus, rd_bus, wr_bus}, 0);
      rst = 1'b0;

      // Both masters contend from reset: expect 0,1,0,1
      fork
         begin
            master_txn(0, K_RD, 32'h0000_0010, 0, 0, 0);
            master_txn(0, K_RD, 32'h0000_0024, 0, 0, 0);
         end
         begin
            master_txn(1, K_RD, 32'h0000_0108, 0, 0, 0);
            master_txn(1, K_RD, 32'h0000_011C, 0, 0, 0);
         end
      join
      chk("order_len", gorder.size(), 4);
      for (int k = 0; k < 4; k++)
         chk("order", (k < gorder.size()) ? gorder[k] : 99, k % 2);

      repeat (3) @(posedge clk);
      master_txn(0, K_RD, 32'h0000_0008, 0, 0, 0);
      repeat (2) @(posedge clk);
      master_txn(1, K_WR, 32'h0000_0104, 32'hDEAD_BEEF, 4'b0011, 0);
      repeat (2) @(posedge clk);
      master_txn(0, K_ERR, 32'h8000_0040, 0, 0, 0);
      master_txn(1, K_RD, 32'h0000_0200, 0, 0, 0);
      repeat (2) @(posedge clk);
      master_txn(0, K_ABORT, 32'h0000_000C, 0, 0, 2);
      repeat (4) @(posedge clk);

      fork
         master_run(0, 20);
         master_run(1, 20);
      join
      repeat (4) @(posedge clk);

      // Reset while the owner sits in DROP
      x.kind = K_RD; x.addr = 32'h0000_300C; x.data = 0; x.mask = 0;
      sbq[0].push_back(x);
      @(posedge clk); #1;
      m_addr[31:0] = 32'h0000_300C;
      m_rd[0] = 1'b1;
      n = 0;
      while (!m_fc[0] && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("drop_reached", m_fc[0], 1);
      @(posedge clk); #1;
      rst  = 1'b1;
      m_rd = '0;
      #1;
      chk("midrst_grant", grant, 0);
      chk("midrst_fc_err", {m_fc, m_err}, 0);
      chk("midrst_bus", {addr_bus, data_mask_bus, rd_bus, wr_bus}, 0);
      repeat (2) @(posedge clk); #1;
      rst = 1'b0;
      fork
         master_txn(0, K_RD, 32'h0000_0404, 0, 0, 0);
         master_txn(1, K_WR, 32'h0000_0500, 32'h1234_5678, 4'b1111, 0);
      join
      chk("post_rst_first", (gorder.size() > 0) ? gorder[0] : 99, 0);
      repeat (4) @(posedge clk);
      chk("sb_drain0", sbq[0].size(), 0);
      chk("sb_drain1", sbq[1].size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
